// File: rtl/stretch_pkg.sv
// Shared types and helpers for pulse_stretcher: FSM state encoding and a
// constant max() used to size the shared HIGH/GAP timer.
package stretch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle events into pulses with guaranteed high and low times.
// Event queueing while a pulse is in progress is enabled by PULSE_STRETCH_QUEUE_EN.
module pulse_stretcher
    import stretch_pkg::*;
#(
    parameter int HIGH_CYCLES = 50,
    parameter int LOW_CYCLES  = 50,
    parameter int PEND_MAX    = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          event_in,
    output logic                          out_pulse,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pending,
    output logic                          overflow
);

    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int TW = $clog2(max(HIGH_CYCLES, LOW_CYCLES) + 1);
    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ovf_q, ovf_d;
    logic            out_q, out_d;
    logic            timer_done;
    logic            extra_evt;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam logic [PW-1:0] PEND_LIM = PW'(PEND_MAX);
    logic [PW-1:0]   pend_q, pend_d;
`endif

    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        extra_evt = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
        pend_d    = pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (event_in) begin
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
                end
            end
            HIGH: begin
                extra_evt = event_in;
                if (timer_done) begin
                    state_d = GAP;
                    timer_d = LOW_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (!timer_done) begin
                    extra_evt = event_in;
                    timer_d   = timer_q - TW'(1);
`ifdef PULSE_STRETCH_QUEUE_EN
                end else if (event_in || (pend_q != '0)) begin
                    // A live event on the restart cycle takes precedence, leaving the queue intact
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
                    if (!event_in) pend_d = pend_q - PW'(1);
`else
                end else if (event_in) begin
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (extra_evt) begin
`ifdef PULSE_STRETCH_QUEUE_EN
            if (pend_q == PEND_LIM) ovf_d = 1'b1;
            else                    pend_d = pend_q + PW'(1);
`else
            ovf_d = 1'b1;
`endif
        end

        out_d = (state_d == HIGH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

`ifdef PULSE_STRETCH_QUEUE_EN
    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end
    assign pending = pend_q;
`else
    assign pending = '0;
`endif

    assign out_pulse = out_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher; expected behaviour comes from a
// timestamp model of pulse windows (start time, end of gap, queue depth).
module tb_pulse_stretcher;

    localparam int H    = 50;
    localparam int L    = 50;
    localparam int PMAX = 7;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       event_in = 1'b0;
    logic       out_pulse;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: start cycle of latest pulse, last busy cycle, queue depth, sticky overflow
    int m_s   = -1000;
    int m_bu  = -1;
    int m_pend = 0;
    bit m_ovf = 1'b0;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .PEND_MAX   (PMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .event_in (event_in),
        .out_pulse(out_pulse),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_out();
        return (cyc >= m_s) && (cyc < m_s + H);
    endfunction

    function automatic logic exp_busy();
        return cyc <= m_bu;
    endfunction

    // Drive one cycle, advance the model over the sampling edge, settle outputs.
    task automatic step(input logic ev);
        event_in = ev;
        @(posedge clk);
        if (rst) begin
            m_s = -1000; m_bu = -1; m_pend = 0; m_ovf = 1'b0;
        end else if (cyc > m_bu) begin
            if (ev) begin m_s = cyc + 1; m_bu = cyc + H + L; end
        end else if (cyc == m_bu) begin
            if (ev || m_pend > 0) begin
                if (!ev) m_pend--;
                m_s = cyc + 1; m_bu = cyc + H + L;
            end
        end else if (ev) begin
            if (QUEUE && m_pend < PMAX) m_pend++;
            else m_ovf = 1'b1;
        end
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            total++;
            if (out_pulse !== 1'b0 || busy !== 1'b0 || pending !== 3'd0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=0/0/0/0",
                         cyc, out_pulse, busy, pending, overflow);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int t0 = cyc;
        for (int i = 0; i < 130; i++) begin
            step(cyc == t0 + 10);
            total++;
            if (out_pulse !== exp_out() || busy !== exp_busy() ||
                pending !== 3'(m_pend) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL single cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                         cyc, out_pulse, busy, pending, overflow, exp_out(), exp_busy(), m_pend, m_ovf);
            end
            if (cyc == t0 + 11 || cyc == t0 + 60 || cyc == t0 + 61 || cyc == t0 + 110 || cyc == t0 + 111) begin
                total++;
                if (out_pulse !== (cyc <= t0 + 60) || busy !== (cyc <= t0 + 110)) begin
                    bad++;
                    $display("FAIL single_edges cyc=%0d got out/busy=%b/%b exp=%b/%b",
                             cyc - t0, out_pulse, busy, cyc <= t0 + 60, cyc <= t0 + 110);
                end
            end
        end
    endtask

    task automatic test_queue();
        int t0 = cyc;
        for (int i = 0; i < 330; i++) begin
            step(cyc == t0 + 10 || cyc == t0 + 20 || cyc == t0 + 30);
            total++;
            if (out_pulse !== exp_out() || busy !== exp_busy() ||
                pending !== 3'(m_pend) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL queue cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                         cyc, out_pulse, busy, pending, overflow, exp_out(), exp_busy(), m_pend, m_ovf);
            end
            if (cyc == t0 + 21) begin
                total++;
                if (pending !== (QUEUE ? 3'd1 : 3'd0)) begin
                    bad++;
                    $display("FAIL queue_pend21 got=%0d exp=%0d", pending, QUEUE ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int t0 = cyc;
        int rises = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 850; i++) begin
            step(cyc == t0 + 10 || (cyc >= t0 + 12 && cyc <= t0 + 21));
            if (out_pulse === 1'b1 && prev === 1'b0) rises++;
            prev = out_pulse;
            total++;
            if (out_pulse !== exp_out() || busy !== exp_busy() ||
                pending !== 3'(m_pend) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL saturation cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                         cyc, out_pulse, busy, pending, overflow, exp_out(), exp_busy(), m_pend, m_ovf);
            end
            if (cyc == t0 + 22) begin
                total++;
                if (pending !== (QUEUE ? 3'd7 : 3'd0) || overflow !== 1'b1) begin
                    bad++;
                    $display("FAIL saturation_full got pend/ovf=%0d/%b exp=%0d/1",
                             pending, overflow, QUEUE ? 7 : 0);
                end
            end
        end
        total++;
        if (rises !== (QUEUE ? 8 : 1)) begin
            bad++;
            $display("FAIL saturation_pulses got=%0d exp=%0d", rises, QUEUE ? 8 : 1);
        end
    endtask

    task automatic test_restart_edge();
        int t0 = cyc;
        for (int i = 0; i < 440; i++) begin
            step(cyc == t0 + 10 || cyc == t0 + 110 ||
                 cyc == t0 + 220 || cyc == t0 + 225 || cyc == t0 + 226 || cyc == t0 + 320);
            total++;
            if (out_pulse !== exp_out() || busy !== exp_busy() ||
                pending !== 3'(m_pend) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL restart cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                         cyc, out_pulse, busy, pending, overflow, exp_out(), exp_busy(), m_pend, m_ovf);
            end
            if (cyc == t0 + 111 || cyc == t0 + 321) begin
                total++;
                if (out_pulse !== 1'b1 || busy !== 1'b1 ||
                    pending !== ((cyc == t0 + 321 && QUEUE) ? 3'd2 : 3'd0)) begin
                    bad++;
                    $display("FAIL restart_edge cyc=%0d got out/busy/pend=%b/%b/%0d", cyc - t0,
                             out_pulse, busy, pending);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0 = cyc;
        for (int i = 0; i < 180; i++) begin
            rst = (cyc == t0 + 30);
            step(cyc == t0 + 2 || cyc == t0 + 5 || cyc == t0 + 6 || cyc == t0 + 7 || cyc == t0 + 40);
            total++;
            if (out_pulse !== exp_out() || busy !== exp_busy() ||
                pending !== 3'(m_pend) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                         cyc, out_pulse, busy, pending, overflow, exp_out(), exp_busy(), m_pend, m_ovf);
            end
            if (cyc == t0 + 31) begin
                total++;
                if (out_pulse !== 1'b0 || busy !== 1'b0 || pending !== 3'd0 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_abort got out/busy/pend/ovf=%b/%b/%0d/%b exp=0/0/0/0",
                             out_pulse, busy, pending, overflow);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int burst = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(199) == 0) burst = $urandom_range(12, 3);
            rst = ($urandom_range(999) == 0);
            if (burst > 0) begin
                burst--;
                step(1'b1);
            end else begin
                step($urandom_range(29) == 0);
            end
            total++;
            if (out_pulse !== exp_out() || busy !== exp_busy() ||
                pending !== 3'(m_pend) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL random cyc=%0d got out/busy/pend/ovf=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                         cyc, out_pulse, busy, pending, overflow, exp_out(), exp_busy(), m_pend, m_ovf);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_queue();
        test_reset();
        test_saturation();
        test_reset();
        test_restart_edge();
        test_reset();
        test_reset_mid();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
